// File: rtl/dsi_lp_handover.sv
// dsi_lp_handover: arbitrates the DSI LP pads between the MIPI PHY and
// software-driven LP signals. Every ownership change waits for the outgoing
// source to reach LP-11, then holds LP-11 for a guard time before the new
// source takes over. Pad outputs are always registered.
module dsi_lp_handover #(
  parameter int LANES         = 2,
  parameter int GUARD_CYCLES  = 64,
  parameter int DRAIN_TIMEOUT = 1024
) (
  input  logic             clk,
  input  logic             nreset,
  input  logic             req_sel,
  input  logic             err_clr,
  input  logic             sw_lp_cp,
  input  logic             sw_lp_cn,
  input  logic [LANES-1:0] sw_lp_dp,
  input  logic [LANES-1:0] sw_lp_dn,
  input  logic             phy_lp_cp,
  input  logic             phy_lp_cn,
  input  logic [LANES-1:0] phy_lp_dp,
  input  logic [LANES-1:0] phy_lp_dn,
  output logic             lp_cp,
  output logic             lp_cn,
  output logic [LANES-1:0] lp_dp,
  output logic [LANES-1:0] lp_dn,
  output logic             owner,
  output logic             busy,
  output logic             err_timeout
);

  localparam int MAXC = (GUARD_CYCLES > DRAIN_TIMEOUT) ? GUARD_CYCLES : DRAIN_TIMEOUT;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam int W    = 2 + 2 * LANES;

  localparam logic [CW-1:0] GUARD_LOAD = CW'(GUARD_CYCLES - 1);
  localparam logic [CW-1:0] DRAIN_LOAD = CW'(DRAIN_TIMEOUT - 1);

  typedef enum logic [1:0] {
    PHY   = 2'd0,
    SW    = 2'd1,
    DRAIN = 2'd2,
    STOP  = 2'd3
  } state_t;

  state_t        state, state_nx;
  logic          target, target_nx;
  logic          owner_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          err_set;
  logic [W-1:0]  lp_q, lp_nx;

  logic [W-1:0] phy_bus, sw_bus;
  logic         phy_idle, sw_idle, owner_idle;

  assign phy_bus    = {phy_lp_cp, phy_lp_cn, phy_lp_dp, phy_lp_dn};
  assign sw_bus     = {sw_lp_cp, sw_lp_cn, sw_lp_dp, sw_lp_dn};
  assign phy_idle   = &phy_bus;
  assign sw_idle    = &sw_bus;
  assign owner_idle = owner ? sw_idle : phy_idle;

  assign busy        = (state == DRAIN) || (state == STOP);
  assign lp_cp       = lp_q[W-1];
  assign lp_cn       = lp_q[W-2];
  assign lp_dp       = lp_q[2*LANES-1:LANES];
  assign lp_dn       = lp_q[LANES-1:0];

  // Handover sequencing: steady owner -> optional drain -> LP-11 guard -> new owner
  always_comb begin
    state_nx  = state;
    target_nx = target;
    owner_nx  = owner;
    cnt_nx    = cnt;
    err_set   = 1'b0;
    case (state)
      PHY, SW: begin
        if (req_sel != owner) begin
          target_nx = req_sel;
          if (owner_idle) begin
            state_nx = STOP;
            cnt_nx   = GUARD_LOAD;
          end else begin
            state_nx = DRAIN;
            cnt_nx   = DRAIN_LOAD;
          end
        end
      end
      DRAIN: begin
        if (req_sel == owner) begin
          state_nx = owner ? SW : PHY;
        end else if (owner_idle) begin
          state_nx = STOP;
          cnt_nx   = GUARD_LOAD;
        end else if (cnt == '0) begin
          state_nx = STOP;
          cnt_nx   = GUARD_LOAD;
          err_set  = 1'b1;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      STOP: begin
        if (cnt == '0) begin
          owner_nx = target;
          state_nx = target ? SW : PHY;
        end else begin
          cnt_nx = cnt - CW'(1);
        end
      end
      default: begin
        state_nx = STOP;
        cnt_nx   = GUARD_LOAD;
      end
    endcase
  end

  // Pad source selection; the guard state forces LP-11 on every line
  always_comb begin
    lp_nx = phy_bus;
    case (state)
      PHY:     lp_nx = phy_bus;
      SW:      lp_nx = sw_bus;
      DRAIN:   lp_nx = owner ? sw_bus : phy_bus;
      STOP:    lp_nx = '1;
      default: lp_nx = '1;
    endcase
  end

  // Control registers; reset parks the block in the guard phase heading to the PHY
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state  <= STOP;
      target <= 1'b0;
      owner  <= 1'b0;
      cnt    <= GUARD_LOAD;
    end else begin
      state  <= state_nx;
      target <= target_nx;
      owner  <= owner_nx;
      cnt    <= cnt_nx;
    end
  end

  // Registered pad outputs so no input ever reaches the pads combinationally
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      lp_q <= '1;
    end else begin
      lp_q <= lp_nx;
    end
  end

  // Sticky drain-timeout flag; a new timeout beats a simultaneous clear
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      err_timeout <= 1'b0;
    end else if (err_set) begin
      err_timeout <= 1'b1;
    end else if (err_clr) begin
      err_timeout <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dsi_lp_handover.sv
// tb_dsi_lp_handover: four instances (LANES 2/4 x DRAIN_TIMEOUT 16/8, guard 4)
// share one stimulus stream and are each compared every cycle against a
// timestamp-based model of the handover rules, plus literal spot checks.
module tb_dsi_lp_handover;

  localparam int G = 4;

  logic       clk = 1'b0;
  logic       nreset;
  logic       req_sel;
  logic       err_clr;
  logic [9:0] phy_v;
  logic [9:0] sw_v;

  int compared   = 0;
  int mismatched = 0;

  logic [3:0] a_cp, a_cn, a_owner, a_busy, a_err;
  logic [1:0] dp_0, dn_0, dp_2, dn_2;
  logic [3:0] dp_1, dn_1, dp_3, dn_3;

  logic       m_owner [4];
  logic       m_target[4];
  logic       m_err   [4];
  int         m_phase [4];
  longint     m_end   [4];
  logic [9:0] m_lp    [4];
  longint     cyc = 0;

  // free-running block clock
  always #5 clk = ~clk;

  dsi_lp_handover #(.LANES(2), .GUARD_CYCLES(G), .DRAIN_TIMEOUT(16)) dut0 (
    .clk(clk), .nreset(nreset), .req_sel(req_sel), .err_clr(err_clr),
    .sw_lp_cp(sw_v[9]), .sw_lp_cn(sw_v[8]), .sw_lp_dp(sw_v[5:4]), .sw_lp_dn(sw_v[1:0]),
    .phy_lp_cp(phy_v[9]), .phy_lp_cn(phy_v[8]), .phy_lp_dp(phy_v[5:4]), .phy_lp_dn(phy_v[1:0]),
    .lp_cp(a_cp[0]), .lp_cn(a_cn[0]), .lp_dp(dp_0), .lp_dn(dn_0),
    .owner(a_owner[0]), .busy(a_busy[0]), .err_timeout(a_err[0]));

  dsi_lp_handover #(.LANES(4), .GUARD_CYCLES(G), .DRAIN_TIMEOUT(16)) dut1 (
    .clk(clk), .nreset(nreset), .req_sel(req_sel), .err_clr(err_clr),
    .sw_lp_cp(sw_v[9]), .sw_lp_cn(sw_v[8]), .sw_lp_dp(sw_v[7:4]), .sw_lp_dn(sw_v[3:0]),
    .phy_lp_cp(phy_v[9]), .phy_lp_cn(phy_v[8]), .phy_lp_dp(phy_v[7:4]), .phy_lp_dn(phy_v[3:0]),
    .lp_cp(a_cp[1]), .lp_cn(a_cn[1]), .lp_dp(dp_1), .lp_dn(dn_1),
    .owner(a_owner[1]), .busy(a_busy[1]), .err_timeout(a_err[1]));

  dsi_lp_handover #(.LANES(2), .GUARD_CYCLES(G), .DRAIN_TIMEOUT(8)) dut2 (
    .clk(clk), .nreset(nreset), .req_sel(req_sel), .err_clr(err_clr),
    .sw_lp_cp(sw_v[9]), .sw_lp_cn(sw_v[8]), .sw_lp_dp(sw_v[5:4]), .sw_lp_dn(sw_v[1:0]),
    .phy_lp_cp(phy_v[9]), .phy_lp_cn(phy_v[8]), .phy_lp_dp(phy_v[5:4]), .phy_lp_dn(phy_v[1:0]),
    .lp_cp(a_cp[2]), .lp_cn(a_cn[2]), .lp_dp(dp_2), .lp_dn(dn_2),
    .owner(a_owner[2]), .busy(a_busy[2]), .err_timeout(a_err[2]));

  dsi_lp_handover #(.LANES(4), .GUARD_CYCLES(G), .DRAIN_TIMEOUT(8)) dut3 (
    .clk(clk), .nreset(nreset), .req_sel(req_sel), .err_clr(err_clr),
    .sw_lp_cp(sw_v[9]), .sw_lp_cn(sw_v[8]), .sw_lp_dp(sw_v[7:4]), .sw_lp_dn(sw_v[3:0]),
    .phy_lp_cp(phy_v[9]), .phy_lp_cn(phy_v[8]), .phy_lp_dp(phy_v[7:4]), .phy_lp_dn(phy_v[3:0]),
    .lp_cp(a_cp[3]), .lp_cn(a_cn[3]), .lp_dp(dp_3), .lp_dn(dn_3),
    .owner(a_owner[3]), .busy(a_busy[3]), .err_timeout(a_err[3]));

  function automatic int drain_of(int i);
    return (i < 2) ? 16 : 8;
  endfunction

  // bus layout {cp, cn, dp[3:0], dn[3:0]}; two-lane instances only see the low lanes
  function automatic logic [9:0] mask(int i, logic [9:0] v);
    return (i % 2 == 0) ? (v & 10'b11_0011_0011) : v;
  endfunction

  function automatic logic idle(int i, logic [9:0] v);
    return mask(i, v) == mask(i, 10'h3FF);
  endfunction

  function automatic logic [9:0] act_lp(int i);
    case (i)
      0:       return {a_cp[0], a_cn[0], 2'b00, dp_0, 2'b00, dn_0};
      1:       return {a_cp[1], a_cn[1], dp_1, dn_1};
      2:       return {a_cp[2], a_cn[2], 2'b00, dp_2, 2'b00, dn_2};
      default: return {a_cp[3], a_cn[3], dp_3, dn_3};
    endcase
  endfunction

  task automatic checkOutput(input string name, input int inst, input logic [9:0] act,
                             input logic [9:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s dut%0d: got %h expected %h at %0t", name, inst, act, exp, $time);
    end
  endtask

  task automatic applyStimulus(input logic req, input logic [9:0] phy, input logic [9:0] sw);
    req_sel = req;
    phy_v   = phy;
    sw_v    = sw;
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic settle(input logic want);
    bit done = 1'b0;
    for (int n = 0; n < 100 && !done; n++) begin
      if (a_busy == 4'b0000 && a_owner == {4{want}}) done = 1'b1;
      else step();
    end
    compared++;
    if (!done) begin
      mismatched++;
      $display("[TB] FAIL settle: owners %b busy %b, required owners %b idle", a_owner, a_busy, {4{want}});
    end
  endtask

  task automatic pulseClear();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
  endtask

  // reference model: phases with absolute end-cycle stamps instead of counters
  always @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < 4; i++) begin
        m_owner[i]  <= 1'b0;
        m_target[i] <= 1'b0;
        m_phase[i]  <= 2;
        m_end[i]    <= cyc + G;
        m_lp[i]     <= mask(i, 10'h3FF);
        m_err[i]    <= 1'b0;
      end
    end else begin
      for (int i = 0; i < 4; i++) begin
        logic [9:0] src;
        logic       own, tgt, err_s;
        int         ph;
        longint     en, e;
        e     = cyc + 1;
        own   = m_owner[i];
        tgt   = m_target[i];
        ph    = m_phase[i];
        en    = m_end[i];
        err_s = 1'b0;
        src   = own ? sw_v : phy_v;
        m_lp[i] <= (ph == 2) ? mask(i, 10'h3FF) : mask(i, src);
        if (ph == 0) begin
          if (req_sel != own) begin
            tgt = req_sel;
            if (idle(i, src)) begin ph = 2; en = e + G; end
            else begin ph = 1; en = e + drain_of(i); end
          end
        end else if (ph == 1) begin
          if (req_sel == own) ph = 0;
          else if (idle(i, src)) begin ph = 2; en = e + G; end
          else if (e == en) begin ph = 2; en = e + G; err_s = 1'b1; end
        end else begin
          if (e == en) begin own = tgt; ph = 0; end
        end
        m_owner[i]  <= own;
        m_target[i] <= tgt;
        m_phase[i]  <= ph;
        m_end[i]    <= en;
        m_err[i]    <= err_s ? 1'b1 : (err_clr ? 1'b0 : m_err[i]);
      end
      cyc <= cyc + 1;
    end
  end

  // every-cycle comparison of all instances against the model
  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      checkOutput("lp", i, act_lp(i), m_lp[i]);
      checkOutput("owner", i, {9'b0, a_owner[i]}, {9'b0, m_owner[i]});
      checkOutput("busy", i, {9'b0, a_busy[i]}, {9'b0, m_phase[i] != 0});
      checkOutput("err_timeout", i, {9'b0, a_err[i]}, {9'b0, m_err[i]});
    end
  end

  initial begin
    nreset  = 1'b1;
    err_clr = 1'b0;
    applyStimulus(1'b0, 10'b11_1110_1111, 10'b00_0101_1010);
    #1 nreset = 1'b0;
    repeat (3) step();
    nreset = 1'b1;

    $display("[TB] reset release");
    for (int e = 1; e <= 4; e++) begin
      step();
      for (int i = 0; i < 4; i++) checkOutput("rst_ones", i, act_lp(i), 10'h3FF & mask(i, 10'h3FF));
    end
    step();
    for (int i = 0; i < 4; i++) begin
      checkOutput("rst_phy", i, act_lp(i), (i % 2 == 0) ? 10'b11_0010_0011 : 10'b11_1110_1111);
      checkOutput("rst_owner", i, {9'b0, a_owner[i]}, 10'd0);
    end

    $display("[TB] PHY to SW with PHY at LP-11");
    applyStimulus(1'b0, 10'h3FF, 10'b10_1010_0101);
    step();
    req_sel = 1'b1;
    for (int e = 0; e < 4; e++) begin
      step();
      for (int i = 0; i < 4; i++) checkOutput("h_busy", i, {9'b0, a_busy[i]}, 10'd1);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      checkOutput("h_owner", i, {9'b0, a_owner[i]}, 10'd1);
      checkOutput("h_ones", i, act_lp(i), mask(i, 10'h3FF));
    end
    step();
    for (int i = 0; i < 4; i++)
      checkOutput("h_swdata", i, act_lp(i), (i % 2 == 0) ? 10'b10_0010_0001 : 10'b10_1010_0101);

    $display("[TB] drain wait");
    applyStimulus(1'b0, 10'h3FF, 10'h3FF);
    settle(1'b0);
    applyStimulus(1'b1, 10'h000, 10'h3FF);
    for (int e = 0; e < 10; e++) begin
      step();
      for (int i = 0; i < 2; i++) begin
        checkOutput("d_follow", i, act_lp(i), 10'h000);
        checkOutput("d_busy", i, {9'b0, a_busy[i]}, 10'd1);
      end
    end
    phy_v = 10'h3FF;
    step();
    for (int i = 0; i < 2; i++) checkOutput("d_noerr", i, {9'b0, a_err[i]}, 10'd0);
    settle(1'b1);
    pulseClear();

    $display("[TB] drain timeout");
    applyStimulus(1'b0, 10'h3FF, 10'h3FF);
    settle(1'b0);
    applyStimulus(1'b1, 10'h000, 10'h3FF);
    repeat (8) step();
    for (int i = 2; i < 4; i++) begin
      checkOutput("t_pre_lp", i, act_lp(i), 10'h000);
      checkOutput("t_pre_err", i, {9'b0, a_err[i]}, 10'd0);
    end
    step();
    for (int i = 2; i < 4; i++) checkOutput("t_err", i, {9'b0, a_err[i]}, 10'd1);
    step();
    for (int i = 2; i < 4; i++) checkOutput("t_ones", i, act_lp(i), mask(i, 10'h3FF));
    pulseClear();
    for (int i = 2; i < 4; i++) checkOutput("t_clr", i, {9'b0, a_err[i]}, 10'd0);
    settle(1'b1);
    pulseClear();

    applyStimulus(1'b0, 10'h3FF, 10'h3FF);
    settle(1'b0);
    applyStimulus(1'b1, 10'h000, 10'h3FF);
    repeat (8) step();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    for (int i = 2; i < 4; i++) checkOutput("t_setwins", i, {9'b0, a_err[i]}, 10'd1);
    settle(1'b1);
    pulseClear();

    $display("[TB] abort in drain");
    applyStimulus(1'b0, 10'h3FF, 10'h3FF);
    settle(1'b0);
    applyStimulus(1'b1, 10'b10_0101_1010, 10'h3FF);
    for (int e = 0; e < 7; e++) begin
      step();
      if (e == 2) req_sel = 1'b0;
      for (int i = 0; i < 4; i++)
        checkOutput("a_follow", i, act_lp(i), (i % 2 == 0) ? 10'b10_0001_0010 : 10'b10_0101_1010);
    end
    for (int i = 0; i < 4; i++) begin
      checkOutput("a_owner", i, {9'b0, a_owner[i]}, 10'd0);
      checkOutput("a_busy", i, {9'b0, a_busy[i]}, 10'd0);
    end

    $display("[TB] request toggle during guard");
    applyStimulus(1'b1, 10'h3FF, 10'h3FF);
    step();
    step();
    req_sel = 1'b0;
    repeat (3) step();
    for (int i = 0; i < 4; i++) checkOutput("g_owner", i, {9'b0, a_owner[i]}, 10'd1);
    step();
    for (int i = 0; i < 4; i++) checkOutput("g_rebusy", i, {9'b0, a_busy[i]}, 10'd1);
    settle(1'b0);

    $display("[TB] async reset");
    req_sel = 1'b1;
    step();
    step();
    #1 nreset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) begin
      checkOutput("r_ones", i, act_lp(i), mask(i, 10'h3FF));
      checkOutput("r_busy", i, {9'b0, a_busy[i]}, 10'd1);
      checkOutput("r_owner", i, {9'b0, a_owner[i]}, 10'd0);
    end
    step();
    applyStimulus(1'b0, 10'b01_0110_1001, 10'h3FF);
    nreset = 1'b1;
    settle(1'b0);
    step();
    #1 nreset = 1'b0;
    #1;
    for (int i = 0; i < 4; i++) checkOutput("r_ones2", i, act_lp(i), mask(i, 10'h3FF));
    step();
    nreset = 1'b1;
    settle(1'b0);

    $display("[TB] randomized traffic");
    for (int n = 0; n < 3000; n++) begin
      step();
      if ($urandom_range(15) == 0) req_sel = ~req_sel;
      phy_v   = ($urandom_range(9) < 7) ? 10'h3FF : 10'($urandom);
      sw_v    = ($urandom_range(9) < 7) ? 10'h3FF : 10'($urandom);
      err_clr = ($urandom_range(31) == 0);
      if (!nreset) nreset = 1'b1;
      else if ($urandom_range(499) == 0) nreset = 1'b0;
    end
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
